// File: rtl/keypad_matrix_evq.sv
// keypad_matrix_evq: scans a ROWSxCOLS key matrix, debounces each key and queues
// press/release/auto-repeat events in a first-word-fall-through FIFO.
module keypad_matrix_evq #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int DEB_FRAMES = 4,
  parameter int REPEAT_EN  = 1,
  parameter int REP_DELAY  = 50,
  parameter int REP_RATE   = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         RSTn,
  input  logic [COLS-1:0]              col,
  output logic [ROWS-1:0]              row,
  output logic [ROWS*COLS-1:0]         key_state,
  output logic                         light,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [$clog2(ROWS*COLS)-1:0] ev_code,
  output logic                         ev_press,
  output logic                         ev_rep,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt,
  output logic                         overflow,
  input  logic                         ovf_clr
);
  localparam int N   = ROWS * COLS;
  localparam int CW  = $clog2(N);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int RW  = $clog2(ROWS);
  localparam int PW  = $clog2(REP_DELAY + 1) + 1;

  logic [COLS-1:0] col_m, col_s;
  logic [DW-1:0] div_cnt;
  logic [RW-1:0] cur_row;
  logic started, tick, frame_end;
  logic [(ROWS-1)*COLS-1:0] raw;
  logic [N-1:0] raw_now, flip, ks_nx, chg;
  logic [N-1:0][3:0] deb;
  logic [PW-1:0] rep_cnt;
  logic one_held, rep_hit, rep_pend, ser_busy, push, pop, full, wr;
  logic [CW-1:0] ser_idx;
  logic [CW+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;

  assign tick      = div_cnt == DW'(DIV - 1);
  assign frame_end = tick && started && cur_row == RW'(ROWS - 1);
  // the last row is sampled on the frame-end tick itself, so it comes straight from the synchronizer
  assign raw_now   = {~col_s, raw};
  assign ks_nx     = key_state ^ flip;
  assign one_held  = ks_nx != '0 && (ks_nx & (ks_nx - 1'b1)) == '0;
  assign rep_hit   = REPEAT_EN != 0 && flip == '0 && one_held && rep_cnt + 1'b1 == PW'(REP_DELAY);

  always_comb begin
    flip = '0;
    for (int i = 0; i < N; i++) flip[i] = raw_now[i] != key_state[i] && deb[i] == 4'(DEB_FRAMES - 1);
  end

  always_ff @(posedge clk or negedge RSTn)
    if (!RSTn) begin
      col_m <= '1; col_s <= '1; div_cnt <= '0; cur_row <= '0; started <= 1'b0; raw <= '0;
    end else begin
      col_m <= col;
      col_s <= col_m;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) started <= 1'b1;
      if (tick && started) begin
        if (cur_row != RW'(ROWS - 1)) raw[cur_row*COLS +: COLS] <= ~col_s;
        cur_row <= cur_row == RW'(ROWS - 1) ? '0 : cur_row + 1'b1;
      end
    end

  // after a repeat the counter is rewound so the next one lands REP_RATE frames later
  always_ff @(posedge clk or negedge RSTn)
    if (!RSTn) begin
      key_state <= '0; chg <= '0; deb <= '0; rep_cnt <= '0; rep_pend <= 1'b0;
    end else if (frame_end) begin
      key_state <= ks_nx;
      chg <= flip;
      rep_pend <= rep_hit;
      rep_cnt <= (flip != '0 || !one_held) ? '0 : rep_hit ? PW'(REP_DELAY - REP_RATE) : rep_cnt + 1'b1;
      for (int i = 0; i < N; i++) deb[i] <= (raw_now[i] != key_state[i] && !flip[i]) ? deb[i] + 4'd1 : 4'd0;
    end

  assign push = ser_busy && (chg[ser_idx] || (rep_pend && key_state[ser_idx]));
  assign pop  = ev_valid && ev_ready;
  assign full = cnt == (AW + 1)'(FIFO_DEPTH);
  assign wr   = push && (!full || pop);

  always_ff @(posedge clk) if (wr) mem[wp] <= {ser_idx, key_state[ser_idx], rep_pend};

  always_ff @(posedge clk or negedge RSTn)
    if (!RSTn) begin
      ser_busy <= 1'b0; ser_idx <= '0; wp <= '0; rp <= '0; cnt <= '0; overflow <= 1'b0;
    end else begin
      if (frame_end) begin
        ser_busy <= 1'b1;
        ser_idx <= '0;
      end else if (ser_busy) begin
        ser_idx <= ser_idx + 1'b1;
        ser_busy <= ser_idx != CW'(N - 1);
      end
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= (wr && !pop) ? cnt + 1'b1 : (pop && !wr) ? cnt - 1'b1 : cnt;
      overflow <= (push && !wr) || (overflow && !ovf_clr);
    end

  assign ev_valid = cnt != '0;
  assign {ev_code, ev_press, ev_rep} = ev_valid ? mem[rp] : '0;
  assign fifo_cnt = cnt;
  assign light = |key_state;
  assign row = started ? ~(ROWS'(1) << cur_row) : '1;
endmodule

// File: tb/tb_keypad_matrix_evq.sv
// tb_keypad_matrix_evq: frame-level reference model feeds an expected-event queue;
// a negedge monitor pops and compares every accepted FIFO head.
module tb_keypad_matrix_evq;
  localparam int R = 4, C = 4, N = 16, CW = 4, D = 4, DEB = 3, RD = 5, RR = 2, DIV = 10;
  typedef struct packed { logic [CW-1:0] code; logic press; logic rep; } ev_t;

  logic clk = 1'b0, RSTn = 1'b0, ev_ready = 1'b0, ovf_clr = 1'b0;
  logic [C-1:0] col;
  logic [R-1:0] row;
  logic [N-1:0] key_state, m_ks;
  logic [N-1:0] pressed = '0;
  logic light, ev_valid, ev_press, ev_rep, overflow, m_ovf;
  logic [CW-1:0] ev_code;
  logic [2:0] fifo_cnt;
  ev_t exp_q[$];
  int m_deb[N];
  int m_rc, rdy_mode;
  int n_vec = 0, n_err = 0;

  keypad_matrix_evq #(.ROWS(R), .COLS(C), .CLK_HZ(1000), .SCAN_HZ(100), .DEB_FRAMES(DEB),
                      .REPEAT_EN(1), .REP_DELAY(RD), .REP_RATE(RR), .FIFO_DEPTH(D)) dut (
    .clk(clk), .RSTn(RSTn), .col(col), .row(row), .key_state(key_state), .light(light),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_press(ev_press),
    .ev_rep(ev_rep), .fifo_cnt(fifo_cnt), .overflow(overflow), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  always_comb begin
    col = '1;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (pressed[r*C+c] && !row[r]) col[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (RSTn && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_event: got code=%0d press=%0d rep=%0d, required no event", ev_code, ev_press, ev_rep);
      end else begin
        e = exp_q.pop_front();
        chk("event{code,press,rep}", {ev_code, ev_press, ev_rep}, e);
      end
    end
  end

  task automatic model_reset();
    m_ks = '0;
    m_rc = 0;
    m_ovf = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) m_deb[i] = 0;
  endtask

  // One frame of keys seen as 'pat': debounce, repeat bookkeeping, events in code order
  task automatic model_frame(input logic [N-1:0] pat);
    logic [N-1:0] chg = '0;
    bit rep = 0;
    ev_t e;
    for (int i = 0; i < N; i++)
      if (pat[i] != m_ks[i]) begin
        m_deb[i]++;
        if (m_deb[i] == DEB) begin
          m_ks[i] = ~m_ks[i];
          m_deb[i] = 0;
          chg[i] = 1'b1;
        end
      end else m_deb[i] = 0;
    if (chg != '0 || $countones(m_ks) != 1) m_rc = 0;
    else begin
      m_rc++;
      rep = m_rc >= RD && (m_rc - RD) % RR == 0;
    end
    for (int i = 0; i < N; i++)
      if (chg[i] || (rep && m_ks[i])) begin
        e.code = CW'(i);
        e.press = m_ks[i];
        e.rep = rep;
        if (rdy_mode == 0 && exp_q.size() >= D) m_ovf = 1'b1;
        else exp_q.push_back(e);
      end
  endtask

  task automatic sync_start();
    bit seen = 0;
    for (int t = 0; t < 3*DIV && !seen; t++) begin
      @(posedge clk); #1;
      seen = !row[0];
    end
    if (!seen) begin
      $display("FAIL first_tick: row=%b, required row[0]=0 within %0d clocks", row, 3*DIV);
      $fatal(1);
    end
    chk("row_first_tick", 32'(row), 32'(4'b1110));
  endtask

  // Apply 'pat' from a frame start until the next frame end, then check against the model
  task automatic frame(input logic [N-1:0] pat);
    bit seen = 0;
    logic prev = row[0];
    pressed = pat;
    for (int t = 0; t < 2*R*DIV && !seen; t++) begin
      ev_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? (t >= 20 || $urandom_range(0, 1) == 1) : 1'b0;
      @(posedge clk); #1;
      seen = prev && !row[0];
      prev = row[0];
    end
    if (!seen) begin
      $display("FAIL frame_end: no frame end within %0d clocks, row=%b", 2*R*DIV, row);
      $fatal(1);
    end
    if (rdy_mode != 0) chk("events_drained", exp_q.size(), 0);
    model_frame(pat);
    chk("key_state", 32'(key_state), 32'(m_ks));
    chk("light", 32'(light), 32'(|m_ks));
  endtask

  task automatic check_reset();
    chk("rst_row", 32'(row), 32'(4'b1111));
    chk("rst_key_state", 32'(key_state), 0);
    chk("rst_light", 32'(light), 0);
    chk("rst_ev_valid", 32'(ev_valid), 0);
    chk("rst_ev_code", 32'(ev_code), 0);
    chk("rst_ev_press", 32'(ev_press), 0);
    chk("rst_ev_rep", 32'(ev_rep), 0);
    chk("rst_fifo_cnt", 32'(fifo_cnt), 0);
    chk("rst_overflow", 32'(overflow), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] p;
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    model_reset();
    RSTn = 1'b1;
    sync_start();
    repeat (5) frame(16'h0040);
    repeat (5) frame('0);
    for (int k = 0; k < 6; k++) frame(16'(k % 2 == 0));
    repeat (5) frame(16'h0001);
    repeat (4) frame('0);
    repeat (4) frame(16'h1008);
    repeat (4) frame('0);
    repeat (15) frame(16'h0200);
    repeat (5) frame(16'h0600);
    repeat (4) frame('0);
    rdy_mode = 0;
    repeat (3) frame(16'h0007);
    repeat (3) frame('0);
    repeat (N + 4) @(posedge clk);
    #1;
    chk("ovf_fifo_cnt", 32'(fifo_cnt), exp_q.size());
    chk("ovf_sticky", 32'(overflow), 32'(m_ovf));
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'(m_ovf));
    chk("ovf_fifo_kept", 32'(fifo_cnt), exp_q.size());
    rdy_mode = 1;
    repeat (3) frame('0);
    rdy_mode = 2;
    for (int k = 0; k < 30; k++) begin
      p = '0;
      repeat ($urandom_range(0, 2)) p[$urandom_range(0, N - 1)] = 1'b1;
      repeat ($urandom_range(1, 8)) frame(p);
    end
    repeat (4) frame('0);
    chk("no_overflow_random", 32'(overflow), 0);
    rdy_mode = 0;
    repeat (3) frame(16'h0003);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_fifo_cnt", 32'(fifo_cnt), exp_q.size());
    RSTn = 1'b0;
    #1;
    check_reset();
    pressed = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    RSTn = 1'b1;
    rdy_mode = 1;
    sync_start();
    repeat (4) frame(16'h8000);
    repeat (4) frame('0);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
